// File: rtl/rectify_pkg.sv
// rtl/rectify_pkg.sv - shared types and widths for the rectification frame reader
//
// Purpose: FSM state encoding, coordinate/address/length widths and the
// default frame geometry used by the frame reader and its sub-modules.
// Ports: none (package).

package rectify_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 16;

  localparam int DEF_COL = 640;
  localparam int DEF_ROW = 480;

endpackage

// File: rtl/rectify_frame_reader_if.sv
// rtl/rectify_frame_reader_if.sv - command, pixel-in and pixel-out bundle of the frame reader
//
// Purpose: groups the line read command channel, the returned pixel beats and
// the coordinate-tagged output pixel stream.
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  line read command to the read master
//   din_valid/din_data                    returned pixel beats (no backpressure)
//   dout_valid/dout_data/col_cnt/row_cnt  registered output pixel and coordinates
//   sof/eol/eof                           frame/line flags, qualified by dout_valid
// Modports: master = frame reader side, slave = read master / datapath side.

interface rectify_frame_reader_if #(
  parameter int DW = 8
);

  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [rectify_pkg::ADDR_W-1:0]   cmd_addr;
  logic [rectify_pkg::LEN_W-1:0]    cmd_len;

  logic                             din_valid;
  logic [DW-1:0]                    din_data;

  logic                             dout_valid;
  logic [DW-1:0]                    dout_data;
  logic [rectify_pkg::COORD_W-1:0]  col_cnt;
  logic [rectify_pkg::COORD_W-1:0]  row_cnt;
  logic                             sof;
  logic                             eol;
  logic                             eof;

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  din_valid, din_data,
    output dout_valid, dout_data, col_cnt, row_cnt, sof, eol, eof
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output din_valid, din_data,
    input  dout_valid, dout_data, col_cnt, row_cnt, sof, eol, eof
  );

endinterface

// File: rtl/pix_coord_counter.sv
// rtl/pix_coord_counter.sv - column/row counter for incoming pixel beats
//
// Purpose: tracks the coordinate of the next pixel beat. Column advances on
// every enabled beat and wraps at COL-1; row advances on the column wrap and
// wraps at ROW-1. Counts hold while en is low.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en                  count one beat
//   clr                 synchronous clear to (0,0); wins over en
//   col, row            coordinate of the current beat
//   last_col, last_row  current beat is at the end of a line / the last line

module pix_coord_counter
  import rectify_pkg::*;
#(
  parameter int COL = DEF_COL,
  parameter int ROW = DEF_ROW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last_col,
  output logic               last_row
);

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COL - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROW - 1);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/rectify_frame_reader.sv
// rtl/rectify_frame_reader.sv - frame-level line read controller with coordinate-tagged output
//
// Purpose: on start, issues one read command per image line (bounded number of
// lines in flight), counts returned pixel beats and re-emits them one cycle
// later with column/row and sof/eol/eof.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, frame_base frame start request and frame byte address
//   busy, done, err   frame in progress, completion pulse, sticky stray-beat error
//   bus (master)      command channel, pixel input, pixel output

module rectify_frame_reader
  import rectify_pkg::*;
#(
  parameter int DIN_DATA_WIDTH = 8,
  parameter int COL            = DEF_COL,
  parameter int ROW            = DEF_ROW,
  parameter int BYTES_PER_PIX  = 1,
  parameter int STRIDE         = 1024,
  parameter int MAX_OUT        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      frame_base,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  rectify_frame_reader_if.master bus
);

  // Line counters are one bit wider than the coordinate so ROW=1024 fits.
  localparam int                 LCNT_W   = COORD_W + 1;
  localparam logic [LCNT_W-1:0]  ROW_LAST = LCNT_W'(ROW - 1);
  localparam logic [LCNT_W-1:0]  MAX_OUTL = LCNT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0]  STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [LEN_W-1:0]   LINE_LEN = LEN_W'(COL * BYTES_PER_PIX);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [LCNT_W-1:0]          issued_q, issued_d;
  logic [LCNT_W-1:0]          lines_done_q, lines_done_d;
  logic                       err_q, err_d;

  logic                       dv_q, dv_d;
  logic [DIN_DATA_WIDTH-1:0]  data_q, data_d;
  logic [COORD_W-1:0]         ocol_q, ocol_d;
  logic [COORD_W-1:0]         orow_q, orow_d;
  logic                       sof_q, sof_d;
  logic                       eol_q, eol_d;
  logic                       eof_q, eof_d;

  logic                       start_acc;
  logic                       beat_ok;
  logic                       cmd_hs;
  logic [LCNT_W-1:0]          outstanding;
  logic [COORD_W-1:0]         cur_col, cur_row;
  logic                       last_col, last_row;

  assign start_acc   = (state_q == ST_IDLE) && start;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign beat_ok     = bus.din_valid && busy;
  assign outstanding = issued_q - lines_done_q;

  // outstanding only grows by our own handshake, so this cannot drop
  // cmd_valid before the pending command is taken.
  assign bus.cmd_valid = (state_q == ST_ISSUE) && (outstanding < MAX_OUTL);
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_len   = LINE_LEN;
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;

  pix_coord_counter #(
    .COL (COL),
    .ROW (ROW)
  ) u_coord (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (beat_ok),
    .clr      (start_acc),
    .col      (cur_col),
    .row      (cur_row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issued_d     = issued_q;
    lines_done_d = lines_done_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = frame_base;
          issued_d     = '0;
          lines_done_d = '0;
          err_d        = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_hs) begin
          issued_d = issued_q + 1'b1;
          addr_d   = addr_q + STRIDE_A;
          if (issued_q == ROW_LAST) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Leave on the registered eof so done trails the eof pixel by a cycle.
        if (dv_q && eof_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (beat_ok && last_col) begin
      lines_done_d = lines_done_q + 1'b1;
    end

    if (bus.din_valid && !busy) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    dv_d   = beat_ok;
    data_d = data_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    sof_d  = 1'b0;
    eol_d  = 1'b0;
    eof_d  = 1'b0;
    if (beat_ok) begin
      data_d = bus.din_data;
      ocol_d = cur_col;
      orow_d = cur_row;
      sof_d  = (cur_col == '0) && (cur_row == '0);
      eol_d  = last_col;
      eof_d  = last_col && last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issued_q     <= '0;
      lines_done_q <= '0;
      err_q        <= 1'b0;
      dv_q         <= 1'b0;
      data_q       <= '0;
      ocol_q       <= '0;
      orow_q       <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      lines_done_q <= lines_done_d;
      err_q        <= err_d;
      dv_q         <= dv_d;
      data_q       <= data_d;
      ocol_q       <= ocol_d;
      orow_q       <= orow_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
    end
  end

  assign bus.dout_valid = dv_q;
  assign bus.dout_data  = data_q;
  assign bus.col_cnt    = ocol_q;
  assign bus.row_cnt    = orow_q;
  assign bus.sof        = sof_q;
  assign bus.eol        = eol_q;
  assign bus.eof        = eof_q;

endmodule

// File: tb/tb_rectify_frame_reader.sv
// tb/tb_rectify_frame_reader.sv - self-checking bench for rectify_frame_reader
//
// Purpose: drives frames with randomized command acceptance and beat gaps and
// compares against a frame-level model (beat index -> coordinates/flags,
// line index -> address, lines in flight bounded by MAX_OUT).
// Ports: none.

module tb_rectify_frame_reader;

  localparam int DW      = 8;
  localparam int COL     = 4;
  localparam int ROW     = 3;
  localparam int STRIDE  = 8;
  localparam int MAX_OUT = 2;
  localparam int NPIX    = COL * ROW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] frame_base;
  logic        busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  rectify_frame_reader_if #(.DW(DW)) bus ();

  rectify_frame_reader #(
    .DIN_DATA_WIDTH (DW),
    .COL            (COL),
    .ROW            (ROW),
    .BYTES_PER_PIX  (1),
    .STRIDE         (STRIDE),
    .MAX_OUT        (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_base (frame_base),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start         = 1'b0;
    frame_base    = '0;
    bus.cmd_ready = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_data  = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [53:0] got;
    do_reset();
    got = {busy, done, err, bus.cmd_valid, bus.dout_valid, bus.sof, bus.eol, bus.eof,
           bus.cmd_addr, bus.col_cnt, bus.row_cnt};
    n_tests++;
    if (got !== 54'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    n_tests++;
    if (bus.cmd_len !== 16'(COL)) begin
      n_fail++;
      $display("FAIL reset_cmd_len got=%0d want=%0d", bus.cmd_len, COL);
    end
  endtask

  // One full frame against the model; rdy_pct/din_pct set acceptance and beat density.
  task automatic test_frame(input logic [31:0] base, input int rdy_pct, input int din_pct);
    int          issued;
    int          sent;
    bit          pend_v;
    int          pend_idx;
    logic [7:0]  pend_data;
    bit          eof_prev;
    bit          seen_done;
    logic        exp_cv;
    logic [36:0] got_o, exp_o;
    logic [31:0] exp_addr;

    idle_inputs();
    start      = 1'b1;
    frame_base = base;
    step();
    start      = 1'b0;
    issued     = 0;
    sent       = 0;
    pend_v     = 1'b0;
    pend_idx   = 0;
    pend_data  = '0;
    eof_prev   = 1'b0;
    seen_done  = 1'b0;

    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      n_tests++;
      if ({done, busy} !== {eof_prev, !eof_prev}) begin
        n_fail++;
        $display("FAIL frame_done_busy cyc=%0d got done=%b busy=%b want done=%b busy=%b",
                 cyc, done, busy, eof_prev, !eof_prev);
      end

      if (pend_v) begin
        exp_o = {1'b1, pend_data, 10'(pend_idx % COL), 10'(pend_idx / COL),
                 pend_idx == 0, (pend_idx % COL) == COL - 1, pend_idx == NPIX - 1};
      end else begin
        exp_o = '0;
      end
      got_o = {bus.dout_valid, bus.dout_data, bus.col_cnt, bus.row_cnt,
               bus.sof, bus.eol, bus.eof};
      n_tests++;
      if ((pend_v && got_o !== exp_o) || (!pend_v && bus.dout_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL frame_dout cyc=%0d got v=%b d=%h c=%0d r=%0d f=%b%b%b want v=%b d=%h c=%0d r=%0d f=%b%b%b",
                 cyc, got_o[36], got_o[35:28], got_o[27:18], got_o[17:8], got_o[2], got_o[1], got_o[0],
                 exp_o[36], exp_o[35:28], exp_o[27:18], exp_o[17:8], exp_o[2], exp_o[1], exp_o[0]);
      end
      eof_prev = pend_v && (pend_idx == NPIX - 1);

      exp_cv = !done && (issued < ROW) && ((issued - sent / COL) < MAX_OUT);
      n_tests++;
      if (bus.cmd_valid !== exp_cv) begin
        n_fail++;
        $display("FAIL frame_cmd_valid cyc=%0d got=%b want=%b issued=%0d beats=%0d",
                 cyc, bus.cmd_valid, exp_cv, issued, sent);
      end

      if (done) begin
        seen_done = 1'b1;
      end else begin
        bus.cmd_ready = ($urandom_range(99) < rdy_pct);
        start         = ($urandom_range(9) == 0);
        frame_base    = $urandom;
        bus.din_data  = 8'($urandom);
        if (sent < issued * COL && $urandom_range(99) < din_pct) begin
          bus.din_valid = 1'b1;
          pend_v        = 1'b1;
          pend_idx      = sent;
          pend_data     = bus.din_data;
          sent++;
        end else begin
          bus.din_valid = 1'b0;
          pend_v        = 1'b0;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          exp_addr = base + 32'(issued * STRIDE);
          n_tests++;
          if (bus.cmd_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL frame_cmd_addr line=%0d got=%h want=%h", issued, bus.cmd_addr, exp_addr);
          end
          issued++;
        end
        step();
      end
    end

    n_tests++;
    if (!seen_done || issued != ROW || sent != NPIX) begin
      n_fail++;
      $display("FAIL frame_complete got done=%b cmds=%0d beats=%0d want done=1 cmds=%0d beats=%0d",
               seen_done, issued, sent, ROW, NPIX);
    end
    idle_inputs();
    step();
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL frame_after_done got busy/done/err=%b want 000", {busy, done, err});
    end
  endtask

  task automatic test_withheld;
    int hs;
    do_reset();
    start      = 1'b1;
    frame_base = 32'h100;
    step();
    start         = 1'b0;
    bus.cmd_ready = 1'b1;
    hs            = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cmd_valid) hs++;
      step();
    end
    n_tests++;
    if (hs != MAX_OUT || bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL withheld_limit got cmds=%0d cmd_valid=%b want cmds=%0d cmd_valid=0",
               hs, bus.cmd_valid, MAX_OUT);
    end
    bus.cmd_ready = 1'b0;
    for (int b = 0; b < COL; b++) begin
      bus.din_valid = 1'b1;
      bus.din_data  = 8'($urandom);
      step();
      bus.din_valid = 1'b0;
      n_tests++;
      if (bus.cmd_valid !== (b == COL - 1)) begin
        n_fail++;
        $display("FAIL withheld_reissue beat=%0d got cmd_valid=%b want=%b", b, bus.cmd_valid, b == COL - 1);
      end
    end
    n_tests++;
    if (bus.cmd_addr !== 32'h110) begin
      n_fail++;
      $display("FAIL withheld_addr got=%h want=00000110", bus.cmd_addr);
    end
    do_reset();
  endtask

  task automatic test_ready_stall;
    do_reset();
    start      = 1'b1;
    frame_base = 32'h100;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus.cmd_valid, bus.cmd_addr} !== {1'b1, 32'h100}) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got valid=%b addr=%h want valid=1 addr=00000100",
                 i, bus.cmd_valid, bus.cmd_addr);
      end
      step();
    end
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    step();
    n_tests++;
    if ({bus.cmd_valid, bus.cmd_addr} !== {1'b1, 32'h108}) begin
      n_fail++;
      $display("FAIL stall_one_hs got valid=%b addr=%h want valid=1 addr=00000108",
               bus.cmd_valid, bus.cmd_addr);
    end
    do_reset();
  endtask

  task automatic test_idle_err;
    do_reset();
    bus.din_valid = 1'b1;
    bus.din_data  = 8'hA5;
    step();
    bus.din_valid = 1'b0;
    n_tests++;
    if ({err, bus.dout_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_err_set got err/dout_valid/busy=%b want 100", {err, bus.dout_valid, busy});
    end
    step();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_err_sticky got=%b want=1", err);
    end
    start      = 1'b1;
    frame_base = 32'h100;
    step();
    start = 1'b0;
    n_tests++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_err_clear got err/busy=%b want 01", {err, busy});
    end
    do_reset();
  endtask

  task automatic test_reset_mid;
    int          issued;
    int          sent;
    logic [53:0] got;
    do_reset();
    start      = 1'b1;
    frame_base = 32'h100;
    step();
    start         = 1'b0;
    bus.cmd_ready = 1'b1;
    issued        = 0;
    sent          = 0;
    for (int cyc = 0; cyc < 100 && sent < 5; cyc++) begin
      bus.din_data  = 8'($urandom);
      bus.din_valid = (sent < issued * COL);
      if (bus.din_valid) sent++;
      if (bus.cmd_valid) issued++;
      step();
    end
    idle_inputs();
    rst_n = 1'b0;
    step();
    got = {busy, done, err, bus.cmd_valid, bus.dout_valid, bus.sof, bus.eol, bus.eof,
           bus.cmd_addr, bus.col_cnt, bus.row_cnt};
    n_tests++;
    if (got !== 54'd0 || sent != 5) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%h beats=%0d want=0 beats=5", got, sent);
    end
    rst_n         = 1'b1;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    n_tests++;
    if ({err, bus.dout_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_inflight got err/dout_valid=%b want 10", {err, bus.dout_valid});
    end
    test_frame(32'hFFFF_FFF8, 100, 100);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_frame(32'h100, 100, 100);
    test_frame(32'h100, 100, 40);
    test_frame($urandom, 60, 50);
    test_frame($urandom, 30, 85);
    test_withheld();
    test_ready_stall();
    test_idle_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rectify_frame_reader.md
# rectify_frame_reader

Frame-level read controller for the rectification pipeline. On a start pulse it issues one AXI read command per image line to the read master, limits the number of lines in flight, and receives the returned pixel beats. It re-emits the beats as a registered pixel stream with column/row coordinates and start-of-frame, end-of-line and end-of-frame flags. The block sits between the DDR read master and the rectification datapath and replaces free-running coordinate counting with counting tied to frame and command state.

## Interface
- DIN_DATA_WIDTH, 8, pixel width in bits
- COL, 640, pixels per line (≤1024)
- ROW, 480, lines per frame (≤1024)
- BYTES_PER_PIX, 1, bytes per pixel beat
- STRIDE, 1024, byte distance between line start addresses
- MAX_OUT, 2, maximum lines commanded but not fully received (1..4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle frame start request
- frame_base  in  32  frame byte address; sampled when start is accepted
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky: a pixel beat arrived while not busy
- cmd_valid  out  1  line read command valid
- cmd_ready  in  1  read master accepts command
- cmd_addr  out  32  line start byte address
- cmd_len  out  16  line length in bytes, equal to COL*BYTES_PER_PIX
- din_valid  in  1  pixel beat from read master; no backpressure
- din_data  in  DIN_DATA_WIDTH  pixel beat
- dout_valid  out  1  output pixel valid
- dout_data  out  DIN_DATA_WIDTH  output pixel
- col_cnt  out  10  column of dout_data
- row_cnt  out  10  row of dout_data
- sof / eol / eof  out  1 each  first pixel of frame / last pixel of line / last pixel of frame; qualified by dout_valid

## Operation
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE: start accepted. It latches frame_base, clears the counters and err, sets busy, and moves to ISSUE. start is ignored in every other state.
- ISSUE: cmd_valid=1 while outstanding<MAX_OUT.
  - Each cmd_valid&cmd_ready increments lines_issued and adds STRIDE to cmd_addr.
  - Address arithmetic wraps modulo 2^32.
  - After handshake number ROW, go to WAIT.
- outstanding = lines_issued − lines_done. lines_done increments on the beat with col=COL−1.
  - A handshake and a line completion in the same cycle leave outstanding unchanged.
- WAIT: wait for the beat with col=COL−1, row=ROW−1, then go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Pixel counting:
  - col increments on every din_valid and wraps at COL−1. row increments on the col wrap and wraps at ROW−1.
  - Counters hold when din_valid=0; they do not clear on gaps.
- din_valid in IDLE/DONE: the beat is dropped, err is set, and there is no dout_valid.
- Reset values: state IDLE; busy, done, err, cmd_valid, dout_valid, sof, eol, eof all 0; cmd_addr, col_cnt, row_cnt 0; cmd_len constant.

## Timing
- din → dout latency is 1 cycle. dout_data, col_cnt, row_cnt and the flags are all registered together.
- cmd_addr and cmd_len are stable while cmd_valid=1 and cmd_ready=0. cmd_valid never drops without a handshake, except on reset.
- First cmd_valid appears the cycle after start.
- done is asserted the cycle after dout_valid&eof. busy falls in the same cycle as done.
- start may be accepted the cycle after done.
- rst_n low mid-frame aborts immediately. All outputs return to reset values on the next edge. In-flight beats after reset set err.

## Structure
- Shared package rectify_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, DONE)
  - COORD_W=10, ADDR_W=32, LEN_W=16
  - default COL/ROW
- Sub-module pix_coord_counter holds col/row with an enable (din_valid & busy) and a synchronous clear (start accepted), and outputs last_col/last_row.
- Top level holds the FSM, the outstanding counter, the address accumulator and the output register.

## Test plan
All scenarios use COL=4, ROW=3, STRIDE=8, MAX_OUT=2, frame_base=0x100 unless stated.
- cmd_ready tied 1, data returned 2 cycles after each command → commands at 0x100, 0x108, 0x110. sof at (0,0), eol at cols 3, eof at (3,2), done one cycle later, 12 dout beats total.
- Data withheld → exactly 2 commands issued, then cmd_valid=0. The third command is issued the cycle after the 4th beat of line 0.
- cmd_ready low for 5 cycles with cmd_valid high → cmd_addr stays 0x100, and exactly one handshake occurs.
- Gaps inserted in din_valid mid-line → coordinates continue (col 2 follows col 1 after the gap). No extra eol.
- din_valid pulsed in IDLE → err=1 and no dout_valid. Next start clears err.
- rst_n low after 5 beats → all outputs 0 on the next edge. A new start with frame_base=0xFFFFFFF8 gives cmd_addr sequence 0xFFFFFFF8, 0x00000000, 0x00000008 (wrap).
